// File: rtl/exc_seq.sv
// exc_seq -- exception sequencer for the multicycle core.
//
// Owns the 3-bit memory-address mux selector. While idle the main control
// unit's selector passes straight through. When an exception input is seen
// in IDLE the cause is latched and the block steps through:
//   CAPTURE : write EPC (datapath computes PC-4), point mux at vector byte
//   ADDR    : start the memory read, load the wait counter
//   WAIT    : hold the read for MEM_WAIT cycles, latch the handler byte
//   LOAD    : write PC with the zero-extended handler byte
//   DONE    : one-cycle completion pulse
// The main FSM must hold while busy is high.
//
// Parameters:
//   MEM_WAIT       cycles from mem_rd assertion to valid mem_rdata (1..7)
// Ports:
//   clk            core clock, rising edge
//   reset_n        synchronous active-low reset
//   exc_opcode     invalid-opcode pulse (highest priority)
//   exc_ovf        ALU overflow pulse
//   exc_div0       divide-by-zero pulse (lowest priority)
//   main_addr_sel  selector requested by the main control unit
//   mem_rdata      memory read data, [7:0] is the handler address
//   addr_sel       selector driven to the address mux
//   mem_rd         memory read strobe
//   epc_write      EPC write enable
//   pc_write       PC write enable for pc_value
//   pc_value       {24'b0, latched handler byte}
//   cause          01 opcode, 10 overflow, 11 div0, 00 none
//   busy           registered, high from CAPTURE through DONE
//   done           one-cycle pulse in DONE
//   exc_lost       sticky: an exception arrived while busy
module exc_seq #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [2:0]  main_addr_sel,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  addr_sel,
  output logic        mem_rd,
  output logic        epc_write,
  output logic        pc_write,
  output logic [31:0] pc_value,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done,
  output logic        exc_lost
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_ADDR,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  wait_cnt;
  logic [2:0]  vec_sel;
  logic [7:0]  pc_byte;
  logic        any_exc;
  logic [1:0]  cause_new;

  // Only the low byte of the read carries the handler address.
  logic        unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[31:8];

  // Fixed priority: opcode > overflow > divide-by-zero.
  function automatic logic [1:0] encode_cause(input logic opc,
                                              input logic ovf,
                                              input logic div0);
    logic [1:0] c;
    c = 2'b00;
    if (opc)       c = 2'b01;
    else if (ovf)  c = 2'b10;
    else if (div0) c = 2'b11;
    return c;
  endfunction

  // Mux inputs 4/5/6 select the constant vector bytes 253/254/255.
  // Input 7 (constant 0) is never chosen here.
  function automatic logic [2:0] vector_sel(input logic [1:0] c);
    logic [2:0] s;
    case (c)
      2'b01:   s = 3'd4;
      2'b10:   s = 3'd5;
      default: s = 3'd6;
    endcase
    return s;
  endfunction

  assign any_exc   = exc_opcode | exc_ovf | exc_div0;
  assign cause_new = encode_cause(exc_opcode, exc_ovf, exc_div0);
  assign pc_value  = {24'b0, pc_byte};

  // Next state and strobes. Outside IDLE the selector comes from the
  // register latched at acceptance so memory sees a stable address.
  always_comb begin
    state_nxt = state;
    addr_sel  = vec_sel;
    mem_rd    = 1'b0;
    epc_write = 1'b0;
    pc_write  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        addr_sel = main_addr_sel;
        if (any_exc) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        epc_write = 1'b1;
        state_nxt = S_ADDR;
      end
      S_ADDR: begin
        mem_rd    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mem_rd = 1'b1;
        if (wait_cnt == 3'd0) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        pc_write  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
      vec_sel  <= 3'd0;
      pc_byte  <= 8'd0;
      cause    <= 2'b00;
      exc_lost <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_nxt;
      // busy tracks the state being entered so it is a clean register output.
      busy  <= (state_nxt != S_IDLE);

      if (state == S_IDLE && any_exc) begin
        cause   <= cause_new;
        vec_sel <= vector_sel(cause_new);
      end

      // Exceptions are not queued; anything arriving outside IDLE
      // (including the edge that leaves DONE) is only recorded as lost.
      if (state != S_IDLE && any_exc) exc_lost <= 1'b1;

      case (state)
        S_ADDR: wait_cnt <= 3'(MEM_WAIT - 1);
        S_WAIT: begin
          if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
          else                  pc_byte  <= mem_rdata[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/exc_seq.md
# exc_seq

Exception sequencer for the multicycle core. It owns the 3-bit memory-address mux selector. While idle it passes through the main control unit's selector. On an exception it takes the selector and steps through four actions: save EPC, point the mux at the fixed vector byte (253/254/255), wait for memory, and load the zero-extended handler byte into PC. It sits between the main control FSM and the datapath, and stalls the main FSM for the whole sequence.

## Interface
Parameters:
- MEM_WAIT, 1: cycles between mem_rd assertion and valid mem_rdata (legal range 1..7).

Ports:
- clk  in  1  core clock; every register updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- exc_opcode  in  1  invalid-opcode pulse from decode.
- exc_ovf  in  1  ALU overflow pulse.
- exc_div0  in  1  divide-by-zero pulse.
- main_addr_sel  in  3  address-mux selector requested by the main control unit.
- mem_rdata  in  32  memory read data; bits [7:0] hold the handler address.
- addr_sel  out  3  selector driven to the address mux.
- mem_rd  out  1  memory read strobe.
- epc_write  out  1  EPC register write enable; the datapath computes PC-4.
- pc_write  out  1  PC write enable for pc_value.
- pc_value  out  32  {24'b0, latched mem_rdata[7:0]}.
- cause  out  2  latched cause: 01 opcode, 10 overflow, 11 div0, 00 none.
- busy  out  1  high from CAPTURE through DONE; the main FSM must hold while it is high.
- done  out  1  one-cycle pulse in DONE.
- exc_lost  out  1  sticky flag; set when an exception input is asserted while busy.

## Operation
- States:
  - IDLE
  - CAPTURE
  - ADDR
  - WAIT
  - LOAD
  - DONE
- IDLE:
  - addr_sel = main_addr_sel, combinational pass-through.
  - All strobes are 0.
  - If any exc_* input is high at a clock edge, latch the cause and go to CAPTURE.
  - Cause priority when several are high together: opcode > ovf > div0.
- Vector select for the latched cause:
  - opcode selects 3'd4 (address 253).
  - ovf selects 3'd5 (address 254).
  - div0 selects 3'd6 (address 255).
  - 3'd7 (constant 0) is never driven by this block.
- CAPTURE:
  - epc_write=1.
  - addr_sel = vector select (registered from here through DONE).
  - Next state ADDR.
- ADDR:
  - mem_rd=1.
  - Load the wait counter with MEM_WAIT-1.
  - Next state WAIT.
- WAIT:
  - mem_rd=1.
  - Counter decrements each cycle.
  - When the counter is 0 at an edge: latch mem_rdata[7:0] into pc_value[7:0] and go to LOAD.
- LOAD:
  - pc_write=1; pc_value is stable.
  - Next state DONE.
- DONE:
  - done=1, busy=1.
  - Next state IDLE.
  - cause holds its value until the next exception is accepted.
- Exceptions while busy (CAPTURE through DONE):
  - The exception is not queued.
  - exc_lost is set and cleared only by reset.
- An exception input high in the same cycle that DONE is exited is also dropped; the first acceptable edge is one taken in IDLE.
- pc_value[31:8] is always 0.

## Timing
- Reset (reset_n=0 at an edge) forces:
  - state IDLE and counter 0.
  - cause=00, pc_value=0, exc_lost=0.
  - all strobes 0, busy=0, done=0.
  - Reset applies from any state and abandons the sequence mid-operation; no pc_write follows.
- With an exception sampled at edge E0:
  - CAPTURE in cycle E0+1.
  - ADDR in E0+2.
  - WAIT for MEM_WAIT cycles.
  - LOAD at E0+3+MEM_WAIT.
  - DONE at E0+4+MEM_WAIT.
  - IDLE at E0+5+MEM_WAIT.
- With MEM_WAIT=1, the sequence is 6 cycles from acceptance to return to IDLE.
- addr_sel is held constant from CAPTURE through DONE, so the memory sees a stable address for the whole read.
- busy is a registered output.
- addr_sel changes combinationally with main_addr_sel only in IDLE.

## Test plan
- Reset then idle pass-through:
  - Stimulus: main_addr_sel swept 0..7.
  - Required: addr_sel follows it in the same cycle; all strobes 0; cause=00.
- Overflow, MEM_WAIT=1, memory byte 254 = 0x7C:
  - Stimulus: exc_ovf pulse.
  - Required: epc_write at +1; addr_sel=5 from +1 to +5; mem_rd at +2..+3; pc_write with pc_value=0x0000007C at +4; done at +5; cause=10.
- Simultaneous events:
  - Stimulus: exc_opcode, exc_ovf and exc_div0 all high in one cycle.
  - Required: cause=01, addr_sel=4; no second sequence starts.
- Exception while busy:
  - Stimulus: exc_div0 pulsed during WAIT of an opcode sequence.
  - Required: the opcode sequence completes unchanged; exc_lost=1 and stays set until reset.
- Reset mid-operation:
  - Stimulus: reset_n=0 during WAIT.
  - Required: next cycle busy=0, mem_rd=0, no pc_write; a following exc_div0 selects 6 and loads 255's byte.
- MEM_WAIT=3:
  - Required: mem_rd lasts 4 cycles; pc_write at E0+6.
